// File: rtl/id_inst_buffer_pkg.sv
// -----------------------------------------------------------------------------
// id_inst_buffer_pkg
// Shared definitions for the IF->ID instruction buffer:
//   - default PC/instruction widths and the packed {pc, inst} entry width
//   - IF stall-request encodings
//   - pointer-width helper
//   - flush-mode decode used by the buffer's next-state logic
// -----------------------------------------------------------------------------
package id_inst_buffer_pkg;

  localparam int PC_W_DFLT   = 32;
  localparam int INST_W_DFLT = 32;

  // One buffered entry is {pc, inst}.
  localparam int IF_TO_ID_WD = PC_W_DFLT + INST_W_DFLT;

  // IF stall-request encodings.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Pointer width for a DEPTH-entry ring; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // What a flush does to the buffer this cycle.
  typedef enum logic [1:0] {
    FL_NONE = 2'd0,  // normal push/pop
    FL_DROP = 2'd1,  // discard everything
    FL_KEEP = 2'd2   // keep one entry as the delay slot
  } flush_mode_e;

endpackage

// File: rtl/id_inst_buffer_if.sv
// -----------------------------------------------------------------------------
// id_inst_buffer_if
// Handshake bundle between IF, the instruction buffer and ID.
//   in_valid/in_ready/in_pc/in_inst    : IF -> buffer
//   out_valid/out_ready/out_pc/out_inst: buffer -> ID
// Modports:
//   master : pipeline side (drives fetched words and ID's ready)
//   slave  : buffer side
// -----------------------------------------------------------------------------
interface id_inst_buffer_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;

  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );

endinterface

// File: rtl/id_ibuf_ptr.sv
// -----------------------------------------------------------------------------
// id_ibuf_ptr
// Wrap-around pointer for the instruction ring. Width W covers exactly
// 2**W entries, so the natural binary rollover is the modulo-DEPTH wrap.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//   inc_i      : advance by one
//   clr_i      : load clr_val_i (has priority over inc_i)
//   clr_val_i  : value loaded on clear
//   ptr_o      : current pointer
// -----------------------------------------------------------------------------
module id_ibuf_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] clr_val_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // NOTE: combinational logic uses blocking assignments and gives every
  // output a default first, so no path leaves a signal unassigned (no latch).
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = clr_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments; the reset here is
  // synchronous, so rst is sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/id_inst_buffer.sv
// -----------------------------------------------------------------------------
// id_inst_buffer
// DEPTH-entry circular FIFO of {pc, inst} between IF and ID. Fetched words
// are accepted while ID is stalled and handed to ID with valid/ready.
// A branch flush empties the buffer, or keeps one entry (the MIPS delay
// slot) relocated to index 0. Cycles in which IF offered a word that could
// not be accepted are counted in a saturating counter.
// DEPTH must be a power of two and >= 2.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush        : discard buffered entries (branch taken in ID)
//   flush_keep   : with flush, keep the oldest unconsumed entry
//   bus          : IF/ID handshake (slave view)
//   count        : current occupancy, 0..DEPTH
//   stallreq_if  : IF stall request, asserted when the buffer is full
//   bp_cycles    : saturating count of in_valid && !in_ready cycles
// -----------------------------------------------------------------------------
module id_inst_buffer
  import id_inst_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = PC_W_DFLT,
  parameter int INST_W = INST_W_DFLT,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     flush_keep,
  id_inst_buffer_if.slave          bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     stallreq_if,
  output logic [CNT_W-1:0]         bp_cycles
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = PC_W + INST_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] bp_q, bp_d;

  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;
  flush_mode_e      mode;

  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [EW-1:0]    wr_data;
  logic             wr_clr_one;
  logic [EW-1:0]    head;

  // Ready depends only on registered occupancy: a full buffer refuses a
  // push even in a cycle where ID pops, which keeps out_ready off the
  // in_ready timing path.
  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0) && !flush;
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  // Head entry; an empty buffer presents zeros rather than stale storage.
  assign head = (count_q != '0) ? mem_q[rd_ptr] : '0;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = head[EW-1:INST_W];
  assign bus.out_inst  = head[INST_W-1:0];

  assign count       = count_q;
  assign stallreq_if = in_ready ? NO_STOP : STOP;
  assign bp_cycles   = bp_q;

  always_comb begin
    mode = FL_NONE;
    if (flush) begin
      mode = flush_keep ? FL_KEEP : FL_DROP;
    end
  end

  // Occupancy and the single storage write port.
  always_comb begin
    count_d    = count_q;
    wr_en      = 1'b0;
    wr_idx     = wr_ptr;
    wr_data    = {bus.in_pc, bus.in_inst};
    wr_clr_one = 1'b0;

    unique case (mode)
      FL_NONE: begin
        wr_en   = push;
        count_d = count_q + CW'(push) - CW'(pop);
      end
      FL_DROP: begin
        count_d = '0;
      end
      FL_KEEP: begin
        // pop is forced low by flush, so the survivor is the current head
        // if there is one, else the word being fetched this cycle.
        count_d = '0;
        if (count_q != '0) begin
          wr_en      = 1'b1;
          wr_idx     = '0;
          wr_data    = mem_q[rd_ptr];
          wr_clr_one = 1'b1;
          count_d    = CW'(1);
        end else if (push) begin
          wr_en      = 1'b1;
          wr_idx     = '0;
          wr_clr_one = 1'b1;
          count_d    = CW'(1);
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_comb begin
    bp_d = bp_q;
    if (bus.in_valid && !in_ready && (bp_q != '1)) begin
      bp_d = bp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      bp_q    <= '0;
    end else begin
      count_q <= count_d;
      bp_q    <= bp_d;
    end
  end

  // NOTE: the storage array has no reset; count gates every read, so stale
  // contents are never visible and the array can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  id_ibuf_ptr #(.W(PW)) u_rd_ptr (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (pop),
    .clr_i     (flush),
    .clr_val_i ('0),
    .ptr_o     (rd_ptr)
  );

  // After a keep-flush the survivor sits at index 0, so writing resumes at 1.
  id_ibuf_ptr #(.W(PW)) u_wr_ptr (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (push && !flush),
    .clr_i     (flush),
    .clr_val_i (wr_clr_one ? PW'(1) : PW'(0)),
    .ptr_o     (wr_ptr)
  );

endmodule

// File: tb/tb_id_inst_buffer.sv
module tb_id_inst_buffer;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int CNT_W  = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   flush_keep;
  logic [$clog2(DEPTH):0] count;
  logic                   stallreq_if;
  logic [CNT_W-1:0]       bp_cycles;

  id_inst_buffer_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

  id_inst_buffer #(
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .INST_W (INST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .flush_keep  (flush_keep),
    .bus         (bus.slave),
    .count       (count),
    .stallreq_if (stallreq_if),
    .bp_cycles   (bp_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t           sb[$];
  logic [CNT_W-1:0] m_bp = '0;
  int               total = 0;
  int               bad   = 0;

  function automatic logic [INST_W-1:0] inst_of(input logic [PC_W-1:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // scoreboard, update the scoreboard, then check the registered state.
  task automatic cycle(input logic rv, input logic iv, input logic [PC_W-1:0] pc,
                       input logic ordy, input logic fl, input logic fk);
    entry_t keep;
    bit     has_keep;
    bit     exp_rdy, exp_ov, do_push, do_pop;
    int     n;
    rst            = rv;
    flush          = fl;
    flush_keep     = fk;
    bus.in_valid   = iv;
    bus.in_pc      = pc;
    bus.in_inst    = inst_of(pc);
    bus.out_ready  = ordy;
    #1;
    n       = sb.size();
    exp_rdy = (n < DEPTH);
    exp_ov  = (n != 0) && !fl;
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("stallreq_if", 64'(stallreq_if), 64'(!exp_rdy));
    check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    if (n != 0) begin
      check("out_pc", 64'(bus.out_pc), 64'(sb[0].pc));
      check("out_inst", 64'(bus.out_inst), 64'(sb[0].inst));
    end else begin
      check("empty_pc", 64'(bus.out_pc), 64'h0);
      check("empty_inst", 64'(bus.out_inst), 64'h0);
    end
    do_push = iv && exp_rdy;
    do_pop  = exp_ov && ordy;
    if (rv) begin
      sb.delete();
      m_bp = '0;
    end else begin
      if (iv && !exp_rdy && (m_bp != '1)) m_bp = m_bp + 1;
      if (fl) begin
        has_keep = 1'b0;
        if (fk && n != 0) begin
          keep     = sb[0];
          has_keep = 1'b1;
        end else if (fk && do_push) begin
          keep.pc   = pc;
          keep.inst = inst_of(pc);
          has_keep  = 1'b1;
        end
        sb.delete();
        if (has_keep) sb.push_back(keep);
      end else begin
        if (do_pop) void'(sb.pop_front());
        if (do_push) begin
          keep.pc   = pc;
          keep.inst = inst_of(pc);
          sb.push_back(keep);
        end
      end
    end
    @(posedge clk);
    #1;
    check("count", 64'(count), 64'(sb.size()));
    check("bp_cycles", 64'(bp_cycles), 64'(m_bp));
  endtask

  task automatic quiet();
    rst           = 1'b0;
    flush         = 1'b0;
    flush_keep    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b0;
    #1;
  endtask

  initial begin
    // Reset
    quiet();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    quiet();
    check("rst_count", 64'(count), 64'h0);
    check("rst_in_ready", 64'(bus.in_ready), 64'h1);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_pc", 64'(bus.out_pc), 64'h0);
    check("rst_out_inst", 64'(bus.out_inst), 64'h0);
    check("rst_bp", 64'(bp_cycles), 64'h0);

    // Fill to full, then three back-pressured cycles
    for (int k = 0; k < 4; k++) cycle(0, 1, 32'h100 + 32'(4 * k), 0, 0, 0);
    quiet();
    check("fill_count", 64'(count), 64'h4);
    check("fill_in_ready", 64'(bus.in_ready), 64'h0);
    check("fill_stallreq", 64'(stallreq_if), 64'h1);
    for (int k = 0; k < 3; k++) cycle(0, 1, 32'h110, 0, 0, 0);
    quiet();
    check("fill_bp", 64'(bp_cycles), 64'h3);
    check("fill_head", 64'(bus.out_pc), 64'h100);

    // Drain in order
    for (int k = 0; k < 4; k++) cycle(0, 0, 32'h0, 1, 0, 0);
    quiet();
    check("drain_out_valid", 64'(bus.out_valid), 64'h0);
    check("drain_count", 64'(count), 64'h0);

    // Steady-state push+pop, pointers wrap several times
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 32'h200 + 32'(4 * k), 1, 0, 0);
      check("wrap_count", 64'(count), 64'h1);
    end
    cycle(0, 0, 32'h0, 1, 0, 0);

    // Flush with drop; the concurrent push is discarded
    for (int k = 0; k < 3; k++) cycle(0, 1, 32'h300 + 32'(4 * k), 0, 0, 0);
    cycle(0, 1, 32'h30C, 0, 1, 0);
    quiet();
    check("drop_count", 64'(count), 64'h0);
    check("drop_out_valid", 64'(bus.out_valid), 64'h0);
    cycle(0, 0, 32'h0, 1, 0, 0);

    // Flush keeping the delay slot (head survives)
    for (int k = 0; k < 3; k++) cycle(0, 1, 32'h400 + 32'(4 * k), 0, 0, 0);
    cycle(0, 0, 32'h0, 1, 1, 1);
    quiet();
    check("keep_count", 64'(count), 64'h1);
    check("keep_out_pc", 64'(bus.out_pc), 64'h400);
    cycle(0, 0, 32'h0, 1, 0, 0);
    // Keep-flush while empty and idle leaves it empty
    cycle(0, 0, 32'h0, 0, 1, 1);
    // Keep-flush while empty with a push keeps the incoming word
    cycle(0, 1, 32'h500, 0, 1, 1);
    quiet();
    check("keep_in_count", 64'(count), 64'h1);
    check("keep_in_out_pc", 64'(bus.out_pc), 64'h500);
    cycle(0, 0, 32'h0, 1, 0, 0);

    // Build count=3, bp_cycles=5, then reset with flush and push
    for (int k = 0; k < 4; k++) cycle(0, 1, 32'h600 + 32'(4 * k), 0, 0, 0);
    for (int k = 0; k < 2; k++) cycle(0, 1, 32'h610, 0, 0, 0);
    cycle(0, 0, 32'h0, 1, 0, 0);
    quiet();
    check("pre_rst_count", 64'(count), 64'h3);
    check("pre_rst_bp", 64'(bp_cycles), 64'h5);
    cycle(1, 1, 32'h700, 0, 1, 1);
    quiet();
    check("mid_rst_count", 64'(count), 64'h0);
    check("mid_rst_bp", 64'(bp_cycles), 64'h0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'h1);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);

    // Buffer works normally after reset
    cycle(0, 1, 32'h800, 0, 0, 0);
    cycle(0, 0, 32'h0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
